// File: rtl/du_pkg.sv
// du_pkg: shared FSM states, rs1 control-bit positions and default widths for dist_fetch_unit
package du_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HIT_OUT = 2'd1, S_FETCH = 2'd2, S_DATA_OUT = 2'd3} du_state_e;
  localparam int RS1_REFETCH = 31;
  localparam int RS1_INVAL   = 30;
  localparam int DEF_DIST_W  = 256;
  localparam int DEF_WORD_W  = 32;
endpackage

// File: rtl/du_slot_cache.sv
// du_slot_cache: NUM_SLOTS x DIST_W distribution store + valid bits; ports we/wslot/wdata write, rslot/rdata read, valid vector, inval_all clears valid
module du_slot_cache import du_pkg::*; #(
  parameter int DIST_W    = DEF_DIST_W,
  parameter int NUM_SLOTS = 4,
  localparam int SLOT_BITS = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [SLOT_BITS-1:0] wslot,
  input  logic [DIST_W-1:0]    wdata,
  input  logic [SLOT_BITS-1:0] rslot,
  output logic [DIST_W-1:0]    rdata,
  output logic [NUM_SLOTS-1:0] valid,
  input  logic                 inval_all
);
  logic [NUM_SLOTS-1:0][DIST_W-1:0] mem_q, mem_d;
  logic [NUM_SLOTS-1:0]             valid_q, valid_d;
  always_comb begin
    mem_d   = mem_q;
    valid_d = inval_all ? '0 : valid_q;
    if (we) begin
      mem_d[wslot]   = wdata;
      valid_d[wslot] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q   <= '0;
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  assign rdata = mem_q[rslot];
  assign valid = valid_q;
endmodule

// File: rtl/dist_fetch_unit.sv
// dist_fetch_unit: cached distribution fetch; DUCtrl/rs1 request in, DU_result/du_clk_stall/du_err out, src_req/src_addr/src_valid/src_data word source
module dist_fetch_unit import du_pkg::*; #(
  parameter int DIST_W    = DEF_DIST_W,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_SLOTS = 4,
  parameter int TIMEOUT   = 255,
  localparam int WORDS     = DIST_W / WORD_W,
  localparam int SLOT_BITS = $clog2(NUM_SLOTS),
  localparam int WIDX_BITS = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int CNT_BITS  = $clog2(TIMEOUT + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           DUCtrl,
  input  logic [31:0]                    rs1,
  output logic [DIST_W-1:0]              DU_result,
  output logic                           du_clk_stall,
  output logic                           du_err,
  output logic                           src_req,
  output logic [SLOT_BITS+WIDX_BITS-1:0] src_addr,
  input  logic                           src_valid,
  input  logic [WORD_W-1:0]              src_data
);
  du_state_e              state_q, state_d;
  logic [SLOT_BITS-1:0]   slot_q, slot_d;
  logic [WIDX_BITS-1:0]   idx_q, idx_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic [DIST_W-1:0]      buf_q, buf_d, result_q, result_d, cache_rdata;
  logic                   stall_q, stall_d, err_q, err_d, req_q, req_d, inv_q, inv_d;
  logic                   we, inval_all, xfer;
  logic [NUM_SLOTS-1:0]   valid;
  logic [SLOT_BITS-1:0]   req_slot;
  logic                   unused_rs1;
  assign req_slot   = rs1[SLOT_BITS-1:0];
  assign unused_rs1 = ^rs1[29:SLOT_BITS];
  assign xfer       = req_q && src_valid;
  du_slot_cache #(.DIST_W(DIST_W), .NUM_SLOTS(NUM_SLOTS)) u_cache (
    .clk(clk), .rst_n(rst_n), .we(we), .wslot(slot_q), .wdata(buf_d),
    .rslot(slot_q), .rdata(cache_rdata), .valid(valid), .inval_all(inval_all)
  );
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    result_d  = result_q;
    stall_d   = stall_q;
    err_d     = 1'b0;
    req_d     = req_q;
    inv_d     = inv_q;
    we        = 1'b0;
    inval_all = 1'b0;
    case (state_q)
      S_IDLE: if (DUCtrl) begin
        slot_d    = req_slot;
        stall_d   = 1'b1;
        inv_d     = rs1[RS1_INVAL];
        inval_all = rs1[RS1_INVAL];
        if (rs1[RS1_INVAL] || (valid[req_slot] && !rs1[RS1_REFETCH])) state_d = S_HIT_OUT;
        else begin
          state_d = S_FETCH;
          idx_d   = '0;
          cnt_d   = '0;
          req_d   = 1'b1;
        end
      end
      S_HIT_OUT: begin
        result_d = inv_q ? result_q : cache_rdata;
        stall_d  = 1'b0;
        state_d  = S_IDLE;
      end
      S_FETCH: if (xfer) begin
        buf_d[idx_q*WORD_W +: WORD_W] = src_data;
        idx_d = idx_q + 1'b1;
        cnt_d = '0;
        if (idx_q == WIDX_BITS'(WORDS - 1)) begin
          we      = 1'b1;
          req_d   = 1'b0;
          state_d = S_DATA_OUT;
        end
      end else if (cnt_q == CNT_BITS'(TIMEOUT - 1)) begin
        req_d    = 1'b0;
        result_d = '0;
        err_d    = 1'b1;
        stall_d  = 1'b0;
        state_d  = S_IDLE;
      end else cnt_d = cnt_q + 1'b1;
      S_DATA_OUT: begin
        result_d = buf_q;
        stall_d  = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        stall_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      buf_q    <= '0;
      result_q <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      result_q <= result_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
      req_q    <= req_d;
      inv_q    <= inv_d;
    end
  assign DU_result    = result_q;
  assign du_clk_stall = stall_q;
  assign du_err       = err_q;
  assign src_req      = req_q;
  assign src_addr     = {slot_q, idx_q};
endmodule
